// File: rtl/rf_wb_arbiter_pkg.sv
// Shared writeback constants, grant encoding and starve-counter helper.
// Default widths mirror the core's DATAWIDTH / OPADDRWIDTH / RF_WB_STARVE_LIMIT.
package rf_wb_arbiter_pkg;

    localparam int RV_DATAWIDTH    = 32;
    localparam int RV_OPADDRWIDTH  = 5;
    localparam int RV_STARVE_LIMIT = 4;
    localparam int STARVE_CNT_W    = 4;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LOAD = 2'd2
    } grant_e;

    // Saturating increment; the counter never needs to count past the limit.
    function automatic logic [STARVE_CNT_W-1:0] starve_next(
        input logic [STARVE_CNT_W-1:0] cnt,
        input logic [STARVE_CNT_W-1:0] limit
    );
        logic [STARVE_CNT_W-1:0] result;
        result = (cnt == limit) ? cnt : cnt + 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard with two query ports.
// With RF_WB_BYPASS_EN defined, a register being written this cycle reads as not busy and flags forwarding.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
#(
    parameter int ADDRWIDTH = RV_OPADDRWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [ADDRWIDTH-1:0] issue_rd,
    input  logic                 clr_en,
    input  logic [ADDRWIDTH-1:0] clr_rd,
    input  logic [ADDRWIDTH-1:0] rs1,
    input  logic [ADDRWIDTH-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy
`ifdef RF_WB_BYPASS_EN
   ,output logic                 rs1_fwd,
    output logic                 rs2_fwd
`endif
);

    localparam int NREGS = 1 << ADDRWIDTH;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    // Set is applied after clear so a re-issue in the retire cycle keeps the register busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && (issue_rd != '0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end else begin
            busy_next = (busy & ~clr_mask) | set_mask;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic hit1;
    logic hit2;

    always_comb begin
        hit1     = clr_en && (clr_rd == rs1) && (rs1 != '0);
        hit2     = clr_en && (clr_rd == rs2) && (rs2 != '0);
        rs1_fwd  = hit1;
        rs2_fwd  = hit2;
        rs1_busy = busy[rs1] && !hit1;
        rs2_busy = busy[rs2] && !hit2;
    end
`else
    always_comb begin
        rs1_busy = busy[rs1];
        rs2_busy = busy[rs2];
    end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the regfile write port: load-priority grant with ALU starvation relief,
// registered write port, and busy scoreboard. Optional bypass via RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATAWIDTH    = RV_DATAWIDTH,
    parameter int ADDRWIDTH    = RV_OPADDRWIDTH,
    parameter int STARVE_LIMIT = RV_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [ADDRWIDTH-1:0] a_rd,
    input  logic [DATAWIDTH-1:0] a_wdata,
    output logic                 a_ready,
    input  logic                 l_valid,
    input  logic [ADDRWIDTH-1:0] l_rd,
    input  logic [DATAWIDTH-1:0] l_wdata,
    output logic                 l_ready,
    input  logic                 issue_valid,
    input  logic [ADDRWIDTH-1:0] issue_rd,
    input  logic                 flush,
    input  logic [ADDRWIDTH-1:0] rs1,
    input  logic [ADDRWIDTH-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rf_we,
    output logic [ADDRWIDTH-1:0] rf_rd,
    output logic [DATAWIDTH-1:0] rf_wdata
`ifdef RF_WB_BYPASS_EN
   ,output logic                 rs1_fwd,
    output logic                 rs2_fwd
`endif
);

    // STARVE_LIMIT is legal in 1..15, so four bits always hold it.
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM_C = STARVE_LIMIT[STARVE_CNT_W-1:0];

    grant_e                  grant;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [ADDRWIDTH-1:0]    win_rd;
    logic [DATAWIDTH-1:0]    win_wdata;
    logic                    wr_en;

    // Load wins by default; a starved ALU request takes the port once.
    always_comb begin
        grant = GRANT_NONE;
        if (rst_n) begin
            if (a_valid && (!l_valid || (starve_cnt == STARVE_LIM_C))) begin
                grant = GRANT_ALU;
            end else if (l_valid) begin
                grant = GRANT_LOAD;
            end
        end
    end

    always_comb begin
        a_ready   = (grant == GRANT_ALU);
        l_ready   = (grant == GRANT_LOAD);
        win_rd    = '0;
        win_wdata = '0;
        case (grant)
            GRANT_ALU: begin
                win_rd    = a_rd;
                win_wdata = a_wdata;
            end
            GRANT_LOAD: begin
                win_rd    = l_rd;
                win_wdata = l_wdata;
            end
            default: begin
                win_rd    = '0;
                win_wdata = '0;
            end
        endcase
        wr_en = (grant != GRANT_NONE) && (win_rd != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (flush || !a_valid || a_ready) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_next(starve_cnt, STARVE_LIM_C);
        end
    end

    // Writes to x0 are accepted but never reach the regfile; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= wr_en;
            if (wr_en) begin
                rf_rd    <= win_rd;
                rf_wdata <= win_wdata;
            end
        end
    end

    rf_scoreboard #(
        .ADDRWIDTH (ADDRWIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .clr_en      (rf_we),
        .clr_rd      (rf_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
`ifdef RF_WB_BYPASS_EN
       ,.rs1_fwd     (rs1_fwd),
        .rs2_fwd     (rs2_fwd)
`endif
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the writeback/scoreboard rules.
module tb_rf_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_wdata;
    logic        a_ready;
    logic        l_valid;
    logic [4:0]  l_rd;
    logic [31:0] l_wdata;
    logic        l_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
`ifdef RF_WB_BYPASS_EN
    logic        rs1_fwd;
    logic        rs2_fwd;
`endif

    rf_wb_arbiter #(
        .DATAWIDTH    (32),
        .ADDRWIDTH    (5),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_wdata     (a_wdata),
        .a_ready     (a_ready),
        .l_valid     (l_valid),
        .l_rd        (l_rd),
        .l_wdata     (l_wdata),
        .l_ready     (l_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata)
`ifdef RF_WB_BYPASS_EN
       ,.rs1_fwd     (rs1_fwd),
        .rs2_fwd     (rs2_fwd)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lwd;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } stim_t;

    int checks   = 0;
    int failures = 0;

    // Reference state: consecutive ALU losses, pending-write set, and the registered write port.
    int          lost;
    bit          m_busy [32];
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    bit          last_alu_win;
    bit          last_load_win;
    logic        obs_a;
    logic        obs_l;
    logic        obs_b1;
    logic        obs_b2;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h time=%0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        lost = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_we = 1'b0;
        m_rd = '0;
        m_wd = '0;
    endtask

    function automatic bit exp_busy(input logic [4:0] rs);
        bit b;
        b = (rs != 5'd0) && m_busy[rs];
`ifdef RF_WB_BYPASS_EN
        if (m_we && (m_rd == rs)) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.av = 1'b0; s.ard = '0; s.awd = '0;
        s.lv = 1'b0; s.lrd = '0; s.lwd = '0;
        s.iv = 1'b0; s.ird = '0; s.fl = 1'b0;
        s.r1 = '0;   s.r2 = '0;
        return s;
    endfunction

    // Drives one cycle starting at a falling edge, checks combinational outputs,
    // advances the model, then checks the registered port at the next falling edge.
    task automatic applyStimulus(input stim_t s);
        bit alu_win;
        bit load_win;
        a_valid     = s.av;  a_rd = s.ard; a_wdata = s.awd;
        l_valid     = s.lv;  l_rd = s.lrd; l_wdata = s.lwd;
        issue_valid = s.iv;  issue_rd = s.ird;
        flush       = s.fl;
        rs1         = s.r1;  rs2 = s.r2;
        #1;
        alu_win  = s.av && (!s.lv || (lost == LIMIT));
        load_win = s.lv && !alu_win;
        obs_a  = a_ready;
        obs_l  = l_ready;
        obs_b1 = rs1_busy;
        obs_b2 = rs2_busy;
        checkOutput("a_ready", 32'(a_ready), 32'(alu_win));
        checkOutput("l_ready", 32'(l_ready), 32'(load_win));
        checkOutput("rs1_busy", 32'(rs1_busy), 32'(exp_busy(s.r1)));
        checkOutput("rs2_busy", 32'(rs2_busy), 32'(exp_busy(s.r2)));
`ifdef RF_WB_BYPASS_EN
        checkOutput("rs1_fwd", 32'(rs1_fwd), 32'(m_we && m_rd == s.r1 && s.r1 != 0));
        checkOutput("rs2_fwd", 32'(rs2_fwd), 32'(m_we && m_rd == s.r2 && s.r2 != 0));
`endif
        last_alu_win  = alu_win;
        last_load_win = load_win;
        if (s.fl) lost = 0;
        else if (s.av && !alu_win) lost = (lost < LIMIT) ? lost + 1 : LIMIT;
        else lost = 0;
        if (s.fl) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            if (m_we) m_busy[m_rd] = 1'b0;
            if (s.iv && s.ird != 0) m_busy[s.ird] = 1'b1;
        end
        if (alu_win && s.ard != 0) begin
            m_we = 1'b1; m_rd = s.ard; m_wd = s.awd;
        end else if (load_win && s.lrd != 0) begin
            m_we = 1'b1; m_rd = s.lrd; m_wd = s.lwd;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("rf_we", 32'(rf_we), 32'(m_we));
        checkOutput("rf_rd", 32'(rf_rd), 32'(m_rd));
        checkOutput("rf_wdata", rf_wdata, m_wd);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        stim_t prev;
        bit    hold_a;
        bit    hold_l;
        int    acnt;
        int    lcnt;

        rst_n = 1'b0;
        s = idle();
        a_valid = 1'b1; a_rd = 5'd5; a_wdata = 32'h11;
        l_valid = 1'b0; l_rd = '0; l_wdata = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
        rs1 = 5'd5; rs2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_a_ready", 32'(a_ready), 32'd0);
        checkOutput("reset_rs1_busy", 32'(rs1_busy), 32'd0);
        checkOutput("reset_rf_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;

        s = idle(); s.av = 1'b1; s.ard = 5'd5; s.awd = 32'h11;
        applyStimulus(s);
        checkOutput("first_we", 32'(rf_we), 32'd1);
        checkOutput("first_rd", 32'(rf_rd), 32'd5);
        checkOutput("first_wdata", rf_wdata, 32'h11);
        applyStimulus(idle());

        // Both producers held: grants follow L,L,L,L,A,...
        acnt = 0; lcnt = 0;
        for (int i = 0; i < 10; i++) begin
            s = idle();
            s.av = 1'b1; s.ard = 5'd10; s.awd = 32'hA0 + 32'(acnt);
            s.lv = 1'b1; s.lrd = 5'd11; s.lwd = 32'hB0 + 32'(lcnt);
            applyStimulus(s);
            checkOutput("contention_alu_grant", 32'(obs_a), 32'((i % 5) == 4));
            if (obs_a) acnt++;
            if (obs_l) lcnt++;
        end
        applyStimulus(idle());

        s = idle(); s.lv = 1'b1; s.lrd = 5'd0; s.lwd = 32'hDEAD;
        applyStimulus(s);
        checkOutput("x0_l_ready", 32'(obs_l), 32'd1);
        checkOutput("x0_rf_we", 32'(rf_we), 32'd0);

        // Scoreboard set / retire / set-wins-over-clear.
        s = idle(); s.iv = 1'b1; s.ird = 5'd7;
        applyStimulus(s);
        s = idle(); s.r1 = 5'd7; s.av = 1'b1; s.ard = 5'd7; s.awd = 32'h77;
        applyStimulus(s);
        checkOutput("sb_busy_after_issue", 32'(obs_b1), 32'd1);
        s = idle(); s.r1 = 5'd7; s.iv = 1'b1; s.ird = 5'd7;
        applyStimulus(s);
`ifdef RF_WB_BYPASS_EN
        checkOutput("sb_bypass_busy", 32'(obs_b1), 32'd0);
`else
        checkOutput("sb_busy_in_clear_cycle", 32'(obs_b1), 32'd1);
`endif
        s = idle(); s.r1 = 5'd7;
        applyStimulus(s);
        checkOutput("sb_set_wins", 32'(obs_b1), 32'd1);

        // Flush with a registered write still retiring.
        s = idle(); s.iv = 1'b1; s.ird = 5'd3;
        applyStimulus(s);
        s = idle(); s.iv = 1'b1; s.ird = 5'd9;
        applyStimulus(s);
        s = idle(); s.av = 1'b1; s.ard = 5'd12; s.awd = 32'hC12;
        applyStimulus(s);
        checkOutput("flush_pending_we", 32'(rf_we), 32'd1);
        checkOutput("flush_pending_rd", 32'(rf_rd), 32'd12);
        s = idle(); s.fl = 1'b1; s.iv = 1'b1; s.ird = 5'd3;
        applyStimulus(s);
        s = idle(); s.r1 = 5'd3; s.r2 = 5'd9;
        applyStimulus(s);
        checkOutput("flush_x3_clear", 32'(obs_b1), 32'd0);
        checkOutput("flush_x9_clear", 32'(obs_b2), 32'd0);

        // Asynchronous reset while an accepted write is on the port.
        s = idle(); s.av = 1'b1; s.ard = 5'd20; s.awd = 32'h2020;
        applyStimulus(s);
        checkOutput("async_pre_we", 32'(rf_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rf_we", 32'(rf_we), 32'd0);
        checkOutput("async_rf_rd", 32'(rf_rd), 32'd0);
        checkOutput("async_a_ready", 32'(a_ready), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(idle());

        // Randomized traffic with producers holding requests until accepted.
        hold_a = 1'b0; hold_l = 1'b0; prev = idle();
        for (int i = 0; i < 1500; i++) begin
            s = idle();
            if (hold_a) begin
                s.av = 1'b1; s.ard = prev.ard; s.awd = prev.awd;
            end else begin
                s.av = ($urandom_range(0, 3) != 0);
                s.ard = 5'($urandom_range(0, 7));
                s.awd = $urandom;
            end
            if (hold_l) begin
                s.lv = 1'b1; s.lrd = prev.lrd; s.lwd = prev.lwd;
            end else begin
                s.lv = ($urandom_range(0, 2) != 0);
                s.lrd = 5'($urandom_range(0, 7));
                s.lwd = $urandom;
            end
            s.iv  = ($urandom_range(0, 2) == 0);
            s.ird = 5'($urandom_range(0, 7));
            s.fl  = ($urandom_range(0, 19) == 0);
            s.r1  = 5'($urandom_range(0, 7));
            s.r2  = 5'($urandom_range(0, 7));
            applyStimulus(s);
            hold_a = s.av && !last_alu_win;
            hold_l = s.lv && !last_load_win;
            prev = s;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
